// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Contents: FSM state enum, requester index constants, read-latency legality check.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  // Wide enough to count 0..RD_LAT_MAX-1.
  localparam int unsigned CNT_W      = 2;

  // Returns 1 when the memory read latency is outside the supported range.
  function automatic logic rd_lat_bad(input int unsigned lat);
    return (lat < RD_LAT_MIN) || (lat > RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the data memory.
// Requester n (n=0 core, n=1 host): rn_req/we/pair/addr/wdata in, rn_gnt/rvalid/rdata/done out.
// Memory side: mem_wr_en/raddr/waddr/wdata out, mem_rdata in. busy: arbiter not idle.
// slave modport = arbiter view, master modport = requesters + memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          r0_req;
  logic          r0_we;
  logic          r0_pair;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;
  logic          r0_done;

  logic          r1_req;
  logic          r1_we;
  logic          r1_pair;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt;
  logic          r1_rvalid;
  logic [DW-1:0] r1_rdata;
  logic          r1_done;

  logic          mem_wr_en;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  r0_req, r0_we, r0_pair, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata, r0_done,
    input  r1_req, r1_we, r1_pair, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata, r1_done,
    output mem_wr_en, mem_raddr, mem_waddr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output r0_req, r0_we, r0_pair, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata, r0_done,
    output r1_req, r1_we, r1_pair, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata, r1_done,
    input  mem_wr_en, mem_raddr, mem_waddr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports: i_req[1:0] pending requests, i_last_gnt index granted last,
//        o_gnt_valid_c any request pending, o_gnt_idx_c index to grant.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic       o_gnt_valid_c,
  output logic       o_gnt_idx_c
);

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    o_gnt_valid_c = |i_req;
    o_gnt_idx_c   = REQ_CORE;
    case (i_req)
      2'b01:   o_gnt_idx_c = REQ_CORE;
      2'b10:   o_gnt_idx_c = REQ_HOST;
      2'b11:   o_gnt_idx_c = ~i_last_gnt;
      default: o_gnt_idx_c = REQ_CORE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the core (r0) and the host (r1).
// Each grant runs one write, one read, or a paired read of addr and addr+1.
// Ports: clk; start = sync active-high reset / abort; bus = requester + memory bundle.
// rX_gnt is combinational in IDLE; every other output is registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                start,
  mem_port_arbiter_if.slave   bus
);

  if (rd_lat_bad(RD_LAT)) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..4");
  end

  arb_state_t       r_state;
  logic             r_idx;
  logic             r_we;
  logic             r_pair_pend;
  logic [AW-1:0]    r_addr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_gnt;
  logic             r_busy;
  logic             r_mem_wr_en;
  logic [AW-1:0]    r_mem_raddr;
  logic [AW-1:0]    r_mem_waddr;
  logic [DW-1:0]    r_mem_wdata;
  logic             r_r0_rvalid;
  logic             r_r1_rvalid;
  logic             r_r0_done;
  logic             r_r1_done;
  logic [DW-1:0]    r_r0_rdata;
  logic [DW-1:0]    r_r1_rdata;

  logic             w_gnt_valid;
  logic             w_gnt_idx;
  logic             w_grant;
  logic             w_sel_we;
  logic             w_sel_pair;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_wdata;
  logic             w_last_beat;

  rr_pick2 u_pick (
    .i_req         ({bus.r1_req, bus.r0_req}),
    .i_last_gnt    (r_last_gnt),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_idx_c   (w_gnt_idx)
  );

  // Grants only from IDLE and never while reset is held.
  assign w_grant     = (r_state == IDLE) && !start && w_gnt_valid;
  assign bus.r0_gnt  = w_grant && (w_gnt_idx == REQ_CORE);
  assign bus.r1_gnt  = w_grant && (w_gnt_idx == REQ_HOST);

  // Fields of the requester being granted.
  assign w_sel_we    = (w_gnt_idx == REQ_HOST) ? bus.r1_we    : bus.r0_we;
  assign w_sel_pair  = (w_gnt_idx == REQ_HOST) ? bus.r1_pair  : bus.r0_pair;
  assign w_sel_addr  = (w_gnt_idx == REQ_HOST) ? bus.r1_addr  : bus.r0_addr;
  assign w_sel_wdata = (w_gnt_idx == REQ_HOST) ? bus.r1_wdata : bus.r0_wdata;

  // Last cycle of the read window: memory data is valid now.
  assign w_last_beat = (r_cnt == CNT_W'(RD_LAT - 1));

  // Sequencer: IDLE -> ACCESS -> RESP (-> ACCESS again for the second pair byte).
  always_ff @(posedge clk) begin
    if (start) begin
      r_state     <= IDLE;
      r_idx       <= REQ_CORE;
      r_we        <= 1'b0;
      r_pair_pend <= 1'b0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_last_gnt  <= REQ_HOST;
      r_busy      <= 1'b0;
      r_mem_wr_en <= 1'b0;
      r_mem_raddr <= '0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
      r_r0_done   <= 1'b0;
      r_r1_done   <= 1'b0;
      r_r0_rdata  <= '0;
      r_r1_rdata  <= '0;
    end else begin
      r_r0_rvalid <= 1'b0;
      r_r1_rvalid <= 1'b0;
      r_r0_done   <= 1'b0;
      r_r1_done   <= 1'b0;
      r_mem_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_idx       <= w_gnt_idx;
            r_we        <= w_sel_we;
            r_pair_pend <= w_sel_pair && !w_sel_we;
            r_addr      <= w_sel_addr;
            r_cnt       <= '0;
            r_last_gnt  <= w_gnt_idx;
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
            if (w_sel_we) begin
              r_mem_wr_en <= 1'b1;
              r_mem_waddr <= w_sel_addr;
              r_mem_wdata <= w_sel_wdata;
            end else begin
              r_mem_raddr <= w_sel_addr;
            end
          end
        end
        ACCESS: begin
          if (r_we) begin
            r_state <= RESP;
            if (r_idx == REQ_HOST) r_r1_done <= 1'b1;
            else                   r_r0_done <= 1'b1;
          end else if (w_last_beat) begin
            r_state <= RESP;
            if (r_idx == REQ_HOST) begin
              r_r1_rdata  <= bus.mem_rdata;
              r_r1_rvalid <= 1'b1;
              r_r1_done   <= !r_pair_pend;
            end else begin
              r_r0_rdata  <= bus.mem_rdata;
              r_r0_rvalid <= 1'b1;
              r_r0_done   <= !r_pair_pend;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (r_pair_pend) begin
            // Second byte of a pair; the address wraps at the top of memory.
            r_pair_pend <= 1'b0;
            r_addr      <= r_addr + 1'b1;
            r_mem_raddr <= r_addr + 1'b1;
            r_cnt       <= '0;
            r_state     <= ACCESS;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.r0_rvalid = r_r0_rvalid;
  assign bus.r0_rdata  = r_r0_rdata;
  assign bus.r0_done   = r_r0_done;
  assign bus.r1_rvalid = r_r1_rvalid;
  assign bus.r1_rdata  = r_r1_rdata;
  assign bus.r1_done   = r_r1_done;
  assign bus.mem_wr_en = r_mem_wr_en;
  assign bus.mem_raddr = r_mem_raddr;
  assign bus.mem_waddr = r_mem_waddr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: two arbiters (RD_LAT=1 and RD_LAT=3) driven by the same requests, each with
// its own memory model; outputs are compared every cycle to timings derived from the
// transaction latency rules and to a reference memory image.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic start;
  always #5 clk = ~clk;

  logic       r0_req, r0_we, r0_pair, r1_req, r1_we, r1_pair;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

  mem_port_arbiter_if #(.AW(8), .DW(8)) if1 ();
  mem_port_arbiter_if #(.AW(8), .DW(8)) if3 ();

  assign if1.r0_req = r0_req;   assign if3.r0_req = r0_req;
  assign if1.r0_we = r0_we;     assign if3.r0_we = r0_we;
  assign if1.r0_pair = r0_pair; assign if3.r0_pair = r0_pair;
  assign if1.r0_addr = r0_addr; assign if3.r0_addr = r0_addr;
  assign if1.r0_wdata = r0_wdata; assign if3.r0_wdata = r0_wdata;
  assign if1.r1_req = r1_req;   assign if3.r1_req = r1_req;
  assign if1.r1_we = r1_we;     assign if3.r1_we = r1_we;
  assign if1.r1_pair = r1_pair; assign if3.r1_pair = r1_pair;
  assign if1.r1_addr = r1_addr; assign if3.r1_addr = r1_addr;
  assign if1.r1_wdata = r1_wdata; assign if3.r1_wdata = r1_wdata;

  mem_port_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) u_dut1 (.clk(clk), .start(start), .bus(if1));
  mem_port_arbiter #(.AW(8), .DW(8), .RD_LAT(3)) u_dut3 (.clk(clk), .start(start), .bus(if3));

  // Memory models: RD_LAT=1 reads combinationally, RD_LAT=3 returns the address seen two edges ago.
  logic [7:0] mem1 [256];
  logic [7:0] mem3 [256];
  logic [7:0] ra3_q1, ra3_q2;
  logic       poke_en;
  logic [7:0] poke_a, poke_d;

  assign if1.mem_rdata = mem1[if1.mem_raddr];
  assign if3.mem_rdata = mem3[ra3_q2];

  always @(posedge clk) begin
    ra3_q1 <= if3.mem_raddr;
    ra3_q2 <= ra3_q1;
    if (start) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= 8'h00;
        mem3[i] <= 8'h00;
      end
    end else begin
      if (poke_en) begin
        mem1[poke_a] <= poke_d;
        mem3[poke_a] <= poke_d;
      end
      if (if1.mem_wr_en) mem1[if1.mem_waddr] <= if1.mem_wdata;
      if (if3.mem_wr_en) mem3[if3.mem_waddr] <= if3.mem_wdata;
    end
  end

  typedef struct {
    logic g0, g1, v0, v1, d0, d1, busy, wr;
    logic [7:0] rd0, rd1, ra, wa, wd;
  } obs_t;

  logic [7:0] ref_mem [256];
  int n_chk = 0;
  int n_pass = 0;

  int         cur_idx;
  int         cur_kind; // 0 write, 1 read, 2 pair read
  logic [7:0] cur_a, cur_d;

  function automatic obs_t grab1();
    obs_t o;
    o.g0 = if1.r0_gnt; o.g1 = if1.r1_gnt; o.v0 = if1.r0_rvalid; o.v1 = if1.r1_rvalid;
    o.d0 = if1.r0_done; o.d1 = if1.r1_done; o.busy = if1.busy; o.wr = if1.mem_wr_en;
    o.rd0 = if1.r0_rdata; o.rd1 = if1.r1_rdata; o.ra = if1.mem_raddr;
    o.wa = if1.mem_waddr; o.wd = if1.mem_wdata;
    return o;
  endfunction

  function automatic obs_t grab3();
    obs_t o;
    o.g0 = if3.r0_gnt; o.g1 = if3.r1_gnt; o.v0 = if3.r0_rvalid; o.v1 = if3.r1_rvalid;
    o.d0 = if3.r0_done; o.d1 = if3.r1_done; o.busy = if3.busy; o.wr = if3.mem_wr_en;
    o.rd0 = if3.r0_rdata; o.rd1 = if3.r1_rdata; o.ra = if3.mem_raddr;
    o.wa = if3.mem_waddr; o.wd = if3.mem_wdata;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Expected per-cycle outputs, k cycles after the grant cycle, from the latency rules.
  task automatic check_dut(input int lat, input string nm, input int k, input obs_t o);
    int   e_end;
    logic e_rv, second;
    string p;
    p      = $sformatf("%s k=%0d", nm, k);
    e_end  = (cur_kind == 0) ? 2 : (cur_kind == 1) ? 1 + lat : 2 + 2 * lat;
    second = (cur_kind == 2) && (k == 2 + 2 * lat);
    e_rv   = (cur_kind != 0) && ((k == 1 + lat) || second);
    chk({p, " gnt0"},   o.g0,   k == 0 && cur_idx == 0);
    chk({p, " gnt1"},   o.g1,   k == 0 && cur_idx == 1);
    chk({p, " rvalid0"}, o.v0,  e_rv && cur_idx == 0);
    chk({p, " rvalid1"}, o.v1,  e_rv && cur_idx == 1);
    chk({p, " done0"},  o.d0,   k == e_end && cur_idx == 0);
    chk({p, " done1"},  o.d1,   k == e_end && cur_idx == 1);
    chk({p, " busy"},   o.busy, k >= 1 && k <= e_end);
    chk({p, " wr_en"},  o.wr,   cur_kind == 0 && k == 1);
    if (e_rv)
      chk({p, " rdata"}, (cur_idx == 0) ? o.rd0 : o.rd1,
          second ? ref_mem[8'(cur_a + 8'd1)] : ref_mem[cur_a]);
    if (cur_kind != 0 && k >= 1 && k <= lat)
      chk({p, " raddr"}, o.ra, cur_a);
    if (cur_kind == 2 && k >= 2 + lat && k <= 1 + 2 * lat)
      chk({p, " raddr2"}, o.ra, 8'(cur_a + 8'd1));
    if (cur_kind == 0 && k == 1) begin
      chk({p, " waddr"}, o.wa, cur_a);
      chk({p, " wdata"}, o.wd, cur_d);
    end
  endtask

  // Issue one transaction (both arbiters idle) and check 12 cycles from the grant.
  task automatic run_txn(input int idx, input int kind, input logic [7:0] a, input logic [7:0] d);
    cur_idx = idx; cur_kind = kind; cur_a = a; cur_d = d;
    if (idx == 0) begin
      r0_req = 1'b1; r0_we = (kind == 0); r0_pair = (kind == 2); r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = 1'b1; r1_we = (kind == 0); r1_pair = (kind == 2); r1_addr = a; r1_wdata = d;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_dut(1, "L1", k, grab1());
      check_dut(3, "L3", k, grab3());
      @(posedge clk); #1;
      if (k == 0) begin r0_req = 1'b0; r1_req = 1'b0; end
    end
    if (kind == 0) ref_mem[a] = d;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic check_all_zero(input string nm, input obs_t o);
    chk({nm, " rst gnt"},    {o.g0, o.g1}, 2'b00);
    chk({nm, " rst rvalid"}, {o.v0, o.v1}, 2'b00);
    chk({nm, " rst done"},   {o.d0, o.d1}, 2'b00);
    chk({nm, " rst busy"},   o.busy, 1'b0);
    chk({nm, " rst wr_en"},  o.wr, 1'b0);
    chk({nm, " rst rdata"},  {o.rd0, o.rd1}, 16'h0);
    chk({nm, " rst addrs"},  {o.ra, o.wa, o.wd}, 24'h0);
  endtask

  int q1 [$];
  int q3 [$];

  initial begin
    obs_t o1, o3;
    logic [7:0] a, d;
    start = 1'b1; poke_en = 1'b0; poke_a = 8'h00; poke_d = 8'h00;
    r0_req = 1'b1; r0_we = 1'b0; r0_pair = 1'b0; r0_addr = 8'h00; r0_wdata = 8'h00;
    r1_req = 1'b0; r1_we = 1'b0; r1_pair = 1'b0; r1_addr = 8'h00; r1_wdata = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Reset: outputs cleared, no grant while start is held even with a request pending.
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("L1", grab1());
    check_all_zero("L3", grab3());
    @(posedge clk); #1;
    start = 1'b0; r0_req = 1'b0;

    // Directed cases.
    run_txn(0, 0, 8'h10, 8'hA5);
    poke(8'h20, 8'h3C);
    run_txn(1, 1, 8'h20, 8'h00);
    run_txn(0, 1, 8'h10, 8'h00);
    poke(8'hFF, 8'h12);
    poke(8'h00, 8'h34);
    run_txn(0, 2, 8'hFF, 8'h00);
    poke(8'h40, 8'($urandom));
    poke(8'h41, 8'($urandom));
    run_txn(1, 2, 8'h40, 8'h00);

    // Randomized traffic over a small preloaded address pool plus the wrap address.
    for (int i = 0; i < 16; i++) poke(8'hC0 + 8'(i), 8'($urandom));
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'hC0 + 8'($urandom_range(0, 15));
      d = 8'($urandom);
      run_txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), a, d);
    end

    // Round robin with both requesters held: grants must alternate starting with r0.
    do_reset();
    poke(8'h30, 8'h55);
    poke(8'h31, 8'h66);
    r0_we = 1'b0; r0_pair = 1'b0; r0_addr = 8'h30;
    r1_we = 1'b0; r1_pair = 1'b0; r1_addr = 8'h31;
    r0_req = 1'b1; r1_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      o1 = grab1(); o3 = grab3();
      chk("L1 rr single gnt", o1.g0 & o1.g1, 1'b0);
      chk("L3 rr single gnt", o3.g0 & o3.g1, 1'b0);
      if (o1.g0 | o1.g1) q1.push_back(int'(o1.g1));
      if (o3.g0 | o3.g1) q3.push_back(int'(o3.g1));
      if (o1.v0) chk("L1 rr rdata0", o1.rd0, ref_mem[8'h30]);
      if (o1.v1) chk("L1 rr rdata1", o1.rd1, ref_mem[8'h31]);
      if (o3.v0) chk("L3 rr rdata0", o3.rd0, ref_mem[8'h30]);
      if (o3.v1) chk("L3 rr rdata1", o3.rd1, ref_mem[8'h31]);
      @(posedge clk); #1;
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("L1 rr grant count", q1.size() >= 8, 1'b1);
    chk("L3 rr grant count", q3.size() >= 6, 1'b1);
    foreach (q1[i]) chk($sformatf("L1 rr order %0d", i), q1[i], i % 2);
    foreach (q3[i]) chk($sformatf("L3 rr order %0d", i), q3[i], i % 2);

    // Abort: start in the first ACCESS cycle of an r0 read after r1 won last.
    run_txn(1, 1, 8'h31, 8'h00);
    poke(8'h50, 8'h77);
    r0_we = 1'b0; r0_pair = 1'b0; r0_addr = 8'h50; r0_req = 1'b1;
    @(negedge clk);
    chk("L1 abort gnt0", if1.r0_gnt, 1'b1);
    chk("L3 abort gnt0", if3.r0_gnt, 1'b1);
    @(posedge clk); #1;
    r0_req = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      o1 = grab1(); o3 = grab3();
      chk("L1 abort quiet", {o1.v0, o1.v1, o1.d0, o1.d1, o1.busy, o1.wr}, 6'b0);
      chk("L3 abort quiet", {o3.v0, o3.v1, o3.d0, o3.d1, o3.busy, o3.wr}, 6'b0);
      @(posedge clk); #1;
    end
    // Reset restored the r0 preference for a tie.
    r1_we = 1'b0; r1_pair = 1'b0; r1_addr = 8'h50;
    r0_req = 1'b1; r1_req = 1'b1;
    @(negedge clk);
    chk("L1 tie after abort", {if1.r0_gnt, if1.r1_gnt}, 2'b10);
    chk("L3 tie after abort", {if3.r0_gnt, if3.r1_gnt}, 2'b10);
    @(posedge clk); #1;
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port data memory (dat_mem: write_en, raddr, waddr, data_in, data_out) between two requesters.
- Requester 0 is the core datapath; requester 1 is the host/loader that preloads and inspects memory.
- Each granted transaction is one write, one read, or a paired read of addr and addr+1 (jump-target fetch {hi, lo}).
- The block owns all memory-side control signals and returns read data with a valid/done handshake.

Parameters:
AW, 8, address width (memory depth 2**AW)
DW, 8, data width
RD_LAT, 1, cycles from mem_raddr stable to mem_data_out valid; legal range 1..4

Ports:
clk  in  1  clock
start  in  1  synchronous active-high reset; also aborts any transaction in flight
r0_req  in  1  core request; held with fields stable until r0_gnt
r0_we  in  1  1 = write, 0 = read
r0_pair  in  1  read addr then addr+1; ignored when r0_we=1
r0_addr  in  AW  address
r0_wdata  in  DW  write data
r0_gnt  out  1  one-cycle pulse; fields latched at this edge
r0_rvalid  out  1  one-cycle pulse; r0_rdata valid
r0_rdata  out  DW  read data, held until next rvalid
r0_done  out  1  one-cycle pulse; transaction complete
r1_req, r1_we, r1_pair, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata, r1_done  (same directions and widths as r0_*)  host requester
mem_wr_en  out  1  to dat_mem write_en
mem_raddr  out  AW  to dat_mem raddr
mem_waddr  out  AW  to dat_mem waddr
mem_wdata  out  DW  to dat_mem data_in
mem_rdata  in  DW  from dat_mem data_out
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: start=1 at an edge clears all registers. After that edge:
  - all outputs are 0 and the state is IDLE;
  - last_gnt = 1, so r0 wins the first tie;
  - while start=1, gnt, rvalid and done stay 0.
- States are IDLE, ACCESS, RESP.
- IDLE:
  - If no request, stay.
  - One request: grant it.
  - Both requests: grant the requester not equal to last_gnt.
  - On the grant cycle, rX_gnt=1 combinationally. At that edge, latch idx, we, pair, addr, wdata; set last_gnt=idx; go to ACCESS.
  - A requester that drops req before gnt has withdrawn; no grant is issued.
- ACCESS, write:
  - mem_waddr = latched addr, mem_wdata = latched wdata, mem_wr_en = 1 for exactly one cycle.
  - Next state is RESP.
- ACCESS, read:
  - mem_raddr = current addr, held for RD_LAT cycles (counter cnt, 0..RD_LAT-1).
  - At the edge where cnt = RD_LAT-1, capture mem_rdata into rX_rdata; go to RESP.
- RESP:
  - Reads: rX_rvalid = 1.
  - Write, single read, or second byte of a pair: rX_done = 1, next state IDLE.
  - First byte of a pair: done = 0; addr <= addr+1 (mod 2**AW, so 0xFF wraps to 0x00); next state ACCESS.
- Latency from the grant cycle T:
  - write done at T+2;
  - read rvalid+done at T+1+RD_LAT;
  - pair rvalid at T+1+RD_LAT, rvalid+done at T+2+2*RD_LAT.
- No grant is issued outside IDLE. The minimum gap from done to the next gnt is 1 cycle.
- A req still high after done is a new request; round-robin then favours the other requester if it is pending.
- mem_wr_en = 0 in every state other than write-ACCESS. mem_raddr and mem_waddr hold their last value when idle.
- The rX_gnt, rvalid and done outputs are only ever asserted for the granted idx; the other requester's stay 0.
- start mid-transaction: at that edge go to IDLE; no rvalid/done for the aborted transaction; mem_wr_en = 0 after the edge.
  - A write whose ACCESS cycle coincides with start=1 may complete in memory; the bench must not check it.
- Widths: the address increment is AW bits and truncating; there is no arithmetic on data.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum arb_state_t {IDLE, ACCESS, RESP};
  - localparam REQ_CORE=0 and REQ_HOST=1;
  - the RD_LAT legality check, as a function that returns an error flag for out-of-range values.
- One sub-module, rr_pick2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last_gnt.
  - Outputs: gnt_valid, gnt_idx.
- All sequencing stays in mem_port_arbiter.

Test Plan:
- Reset then r0 write addr=0x10 wdata=0xA5 -> r0_gnt at T, mem_wr_en=1 with waddr=0x10 at T+1, r0_done at T+2; r1 outputs stay 0.
- Preload mem[0x20]=0x3C, r1 read 0x20, RD_LAT=1 -> r1_rvalid and r1_done at T+2, r1_rdata=0x3C, busy high T+1..T+2.
- r0 and r1 both request in the same cycle, held continuously -> grants alternate r0, r1, r0, r1; no requester is granted twice in a row while the other is pending.
- mem[0xFF]=0x12, mem[0x00]=0x34, r0 pair read at 0xFF -> rvalid with 0x12, then rvalid+done with 0x34; mem_raddr goes 0xFF then 0x00.
- RD_LAT=3, r1 pair read at 0x40 -> mem_raddr=0x40 held for 3 cycles; rvalid at T+4, rvalid+done at T+8.
- start pulsed in the first ACCESS cycle of an r0 read -> no r0_rvalid/done; busy=0 after the edge; next r0 and r1 tie grants r0.
